// File: rtl/video_fetch_agen.sv
// Generic video fetch address walker: lines of words, up to four interleaved planes,
// with a request/acknowledge handshake to the DRAM arbiter.
module video_fetch_agen #(
   parameter int unsigned AW       = 21,
   parameter int unsigned XW       = 7,
   parameter int unsigned YW       = 9,
   parameter int unsigned PLANES   = 2,
   parameter int unsigned PAGE_BIT = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cfg_base,
   input  logic [AW-1:0] cfg_plane_ofs,
   input  logic [15:0]   cfg_stride,
   input  logic [XW-1:0] cfg_words,
   input  logic [YW-1:0] cfg_lines,
   input  logic          cfg_page,
   input  logic          frame_start,
   input  logic          line_start,
   input  logic          vpix,
   output logic [AW-1:0] video_addr,
   output logic          video_req,
   input  logic          video_next,
   output logic [1:0]    plane,
   output logic          busy,
   output logic          underrun
);

   localparam int unsigned SW     = 16;
   localparam logic [1:0]  P_LAST = 2'(PLANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   ofs_q, ofs_d;
   logic [SW-1:0]   stride_q, stride_d;
   logic [XW-1:0]   words_q, words_d;
   logic [YW-1:0]   lines_q, lines_d;
   logic            page_q, page_d;
   logic [AW-1:0]   line_base_q, line_base_d;
   logic [XW-1:0]   x_q, x_d;
   logic [1:0]      p_q, p_d;
   logic [YW-1:0]   y_q, y_d;

   logic [AW-1:0]   video_addr_q, video_addr_d;
   logic            video_req_q, video_req_d;
   logic [1:0]      plane_q, plane_d;
   logic            busy_q, busy_d;
   logic            underrun_q, underrun_d;

   logic            lstart;
   logic            last_x;
   logic            last_y;
   logic            last_p;
   logic [AW-1:0]   next_line_base;
   logic [AW-1:0]   plane_term;

   assign lstart         = line_start & vpix;
   assign last_x         = (x_q == words_q - XW'(1));
   assign last_y         = (y_q == lines_q - YW'(1));
   assign last_p         = (p_q == P_LAST);
   assign next_line_base = line_base_q + AW'(stride_q);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and counter update; frame_start overrides everything else
   always_comb begin
      state_d     = state_q;
      ofs_d       = ofs_q;
      stride_d    = stride_q;
      words_d     = words_q;
      lines_d     = lines_q;
      page_d      = page_q;
      line_base_d = line_base_q;
      x_d         = x_q;
      p_d         = p_q;
      y_d         = y_q;
      underrun_d  = 1'b0;
      if (frame_start) begin
         ofs_d       = cfg_plane_ofs;
         stride_d    = cfg_stride;
         words_d     = cfg_words;
         lines_d     = cfg_lines;
         page_d      = cfg_page;
         line_base_d = cfg_base;
         x_d         = '0;
         p_d         = '0;
         y_d         = '0;
         state_d     = S_WAIT;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (lstart) begin
                  x_d     = '0;
                  p_d     = '0;
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               if (lstart) begin
                  underrun_d  = 1'b1;
                  line_base_d = next_line_base;
                  y_d         = y_q + YW'(1);
                  x_d         = '0;
                  p_d         = '0;
                  state_d     = last_y ? S_IDLE : S_FETCH;
               end else if (video_next) begin
                  if (!last_p) begin
                     p_d = p_q + 2'd1;
                  end else begin
                     p_d = '0;
                     if (last_x) begin
                        x_d         = '0;
                        line_base_d = next_line_base;
                        y_d         = y_q + YW'(1);
                        state_d     = last_y ? S_IDLE : S_WAIT;
                     end else begin
                        x_d = x_q + XW'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from next state: address = line_base + x + p*plane_ofs, page bit forced
   always_comb begin
      case (p_d)
         2'd1:    plane_term = ofs_d;
         2'd2:    plane_term = ofs_d << 1;
         2'd3:    plane_term = (ofs_d << 1) + ofs_d;
         default: plane_term = '0;
      endcase
      video_addr_d           = line_base_d + AW'(x_d) + plane_term;
      video_addr_d[PAGE_BIT] = page_d;
      video_req_d            = (state_d == S_FETCH);
      busy_d                 = (state_d == S_FETCH);
      plane_d                = p_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ofs_q        <= '0;
         stride_q     <= '0;
         words_q      <= '0;
         lines_q      <= '0;
         page_q       <= 1'b0;
         line_base_q  <= '0;
         x_q          <= '0;
         p_q          <= '0;
         y_q          <= '0;
         video_addr_q <= '0;
         video_req_q  <= 1'b0;
         plane_q      <= '0;
         busy_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         ofs_q        <= ofs_d;
         stride_q     <= stride_d;
         words_q      <= words_d;
         lines_q      <= lines_d;
         page_q       <= page_d;
         line_base_q  <= line_base_d;
         x_q          <= x_d;
         p_q          <= p_d;
         y_q          <= y_d;
         video_addr_q <= video_addr_d;
         video_req_q  <= video_req_d;
         plane_q      <= plane_d;
         busy_q       <= busy_d;
         underrun_q   <= underrun_d;
      end
   end

   assign video_addr = video_addr_q;
   assign video_req  = video_req_q;
   assign plane      = plane_q;
   assign busy       = busy_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_video_fetch_agen.sv
// Directed bench for video_fetch_agen (PLANES=2 build): geometry walk, page forcing,
// stalled handshake, early line_start, mid-frame restart, wrap and async reset.
module tb_video_fetch_agen;

   localparam int unsigned AW = 21;
   localparam int unsigned XW = 7;
   localparam int unsigned YW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] cfg_base;
   logic [AW-1:0] cfg_plane_ofs;
   logic [15:0]   cfg_stride;
   logic [XW-1:0] cfg_words;
   logic [YW-1:0] cfg_lines;
   logic          cfg_page;
   logic          frame_start;
   logic          line_start;
   logic          vpix;
   logic [AW-1:0] video_addr;
   logic          video_req;
   logic          video_next;
   logic [1:0]    plane;
   logic          busy;
   logic          underrun;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned fb, fo, fs;
   logic        fp;

   always #18 clk = ~clk;

   video_fetch_agen #(.AW(AW), .XW(XW), .YW(YW), .PLANES(2), .PAGE_BIT(14)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_base      (cfg_base),
      .cfg_plane_ofs (cfg_plane_ofs),
      .cfg_stride    (cfg_stride),
      .cfg_words     (cfg_words),
      .cfg_lines     (cfg_lines),
      .cfg_page      (cfg_page),
      .frame_start   (frame_start),
      .line_start    (line_start),
      .vpix          (vpix),
      .video_addr    (video_addr),
      .video_req     (video_req),
      .video_next    (video_next),
      .plane         (plane),
      .busy          (busy),
      .underrun      (underrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected address for the frame currently latched (fb/fo/fs/fp)
   function automatic logic [31:0] ea(input int unsigned y, input int unsigned x, input int unsigned p);
      logic [AW-1:0] a;
      a     = AW'(fb + fs * y + x + p * fo);
      a[14] = fp;
      return 32'(a);
   endfunction

   task automatic frame(input int unsigned b, input int unsigned o, input int unsigned s,
                        input int unsigned w, input int unsigned l, input logic pg);
      cfg_base      = AW'(b);
      cfg_plane_ofs = AW'(o);
      cfg_stride    = 16'(s);
      cfg_words     = XW'(w);
      cfg_lines     = YW'(l);
      cfg_page      = pg;
      fb = b; fo = o; fs = s; fp = pg;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      // Scramble live config: latched shadows must be unaffected
      cfg_base      = AW'(b ^ 32'h1234);
      cfg_plane_ofs = AW'(o ^ 32'h0055);
      cfg_stride    = 16'(s + 7);
      cfg_words     = XW'(w + 3);
      cfg_lines     = YW'(l + 5);
      cfg_page      = ~pg;
   endtask

   task automatic lstart();
      line_start = 1'b1;
      vpix       = 1'b1;
      tick();
      line_start = 1'b0;
      vpix       = 1'b0;
   endtask

   task automatic run_line(input int unsigned y, input int unsigned words, input int gap);
      for (int unsigned x = 0; x < words; x++) begin
         for (int unsigned p = 0; p < 2; p++) begin
            for (int s = 0; s < gap; s++) begin
               chk("req", 32'(video_req), 32'd1);
               chk("addr", 32'(video_addr), ea(y, x, p));
               chk("plane", 32'(plane), p);
               video_next = (s == gap - 1);
               tick();
            end
         end
      end
      video_next = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cfg_base = '0; cfg_plane_ofs = '0; cfg_stride = '0; cfg_words = '0;
      cfg_lines = '0; cfg_page = 1'b0;
      frame_start = 1'b0; line_start = 1'b0; vpix = 1'b0; video_next = 1'b0;
      fb = 0; fo = 0; fs = 0; fp = 1'b0;
      tick();
      tick();
      chk("rst_addr", 32'(video_addr), 32'h0);
      chk("rst_req", 32'(video_req), 32'h0);
      chk("rst_plane", 32'(plane), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_underrun", 32'(underrun), 32'h0);
      rst = 1'b0;
      tick();

      // Basic two-line walk, page 0 clears bit 14 of the 0x0C000 base
      frame(32'h0C000, 32'h1800, 32, 32, 2, 1'b0);
      chk("wait_req", 32'(video_req), 32'h0);
      lstart();
      chk("first_addr", 32'(video_addr), 32'h08000);
      run_line(0, 32, 1);
      chk("eol_req", 32'(video_req), 32'h0);
      chk("eol_busy", 32'(busy), 32'h0);
      lstart();
      chk("l1_first", 32'(video_addr), 32'h08020);
      run_line(1, 32, 1);
      chk("eof_req", 32'(video_req), 32'h0);
      lstart();
      chk("idle_req", 32'(video_req), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);

      // Page forcing
      frame(32'h0C000, 32'h1800, 32, 32, 2, 1'b1);
      lstart();
      chk("pg_first", 32'(video_addr), 32'h0C000);
      run_line(0, 32, 1);
      chk("pg_eol_req", 32'(video_req), 32'h0);

      // Acknowledge every third cycle
      frame(32'h0C000, 32'h1800, 32, 32, 2, 1'b0);
      lstart();
      run_line(0, 32, 3);
      chk("stall_eol_req", 32'(video_req), 32'h0);

      // Early line_start after 10 acknowledges
      frame(32'h0C000, 32'h1800, 32, 32, 2, 1'b0);
      lstart();
      video_next = 1'b1;
      repeat (10) tick();
      video_next = 1'b0;
      chk("early_pre_addr", 32'(video_addr), 32'h08005);
      chk("early_pre_ur", 32'(underrun), 32'h0);
      lstart();
      chk("early_ur", 32'(underrun), 32'h1);
      chk("early_req", 32'(video_req), 32'h1);
      chk("early_addr", 32'(video_addr), ea(1, 0, 0));
      chk("early_plane", 32'(plane), 32'h0);
      tick();
      chk("early_ur_clr", 32'(underrun), 32'h0);
      chk("early_hold", 32'(video_addr), 32'h08020);
      lstart();
      chk("early_last_ur", 32'(underrun), 32'h1);
      chk("early_last_req", 32'(video_req), 32'h0);
      tick();
      chk("early_last_ur_clr", 32'(underrun), 32'h0);

      // frame_start colliding with line_start and acknowledge mid-line
      frame(32'h0C000, 32'h1800, 32, 32, 2, 1'b0);
      lstart();
      video_next = 1'b1;
      repeat (3) tick();
      cfg_base = AW'(32'h20000); cfg_plane_ofs = AW'(32'h1800); cfg_stride = 16'd32;
      cfg_words = XW'(32); cfg_lines = YW'(2); cfg_page = 1'b0;
      fb = 32'h20000; fo = 32'h1800; fs = 32; fp = 1'b0;
      frame_start = 1'b1; line_start = 1'b1; vpix = 1'b1;
      tick();
      frame_start = 1'b0; line_start = 1'b0; vpix = 1'b0; video_next = 1'b0;
      chk("mid_req", 32'(video_req), 32'h0);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_ur", 32'(underrun), 32'h0);
      lstart();
      chk("mid_addr", 32'(video_addr), 32'h20000);
      chk("mid_plane", 32'(plane), 32'h0);
      chk("mid_req1", 32'(video_req), 32'h1);
      video_next = 1'b1;
      tick();
      video_next = 1'b0;
      chk("mid_addr2", 32'(video_addr), 32'h21800);

      // Address wrap past 2^21 on both plane and word advance, page 1
      frame(32'h1FFFFF, 32'h1, 32, 2, 1, 1'b1);
      lstart();
      video_next = 1'b1;
      chk("wrap0", 32'(video_addr), 32'h1FFFFF);
      tick();
      chk("wrap1", 32'(video_addr), 32'h004000);
      chk("wrap1_plane", 32'(plane), 32'h1);
      tick();
      chk("wrap2", 32'(video_addr), 32'h004000);
      tick();
      chk("wrap3", 32'(video_addr), 32'h004001);
      tick();
      video_next = 1'b0;
      chk("wrap_end_req", 32'(video_req), 32'h0);
      chk("wrap_end_busy", 32'(busy), 32'h0);

      // Asynchronous reset mid-request
      frame(32'h0C000, 32'h1800, 32, 32, 2, 1'b1);
      lstart();
      video_next = 1'b1;
      tick();
      tick();
      video_next = 1'b0;
      chk("pre_rst_req", 32'(video_req), 32'h1);
      rst = 1'b1;
      #1;
      chk("arst_addr", 32'(video_addr), 32'h0);
      chk("arst_req", 32'(video_req), 32'h0);
      chk("arst_plane", 32'(plane), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      tick();
      rst = 1'b0;
      lstart();
      chk("post_rst_req", 32'(video_req), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
